// File: rtl/lcd_cmd_seq_pkg.sv
// LCD command sequencer shared definitions.
// Command codes, legality check and FSM state encoding.
package lcd_cmd_seq_pkg;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_WRITE       = 4'd0;
  localparam cmd_t CMD_SHIFT_FIRST = 4'd1;
  localparam cmd_t CMD_SHIFT_LAST  = 4'd4;
  localparam cmd_t CMD_OP_FIRST    = 4'd5;
  localparam cmd_t CMD_OP_LAST     = 4'd11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  // Codes above the last operation are reserved.
  function automatic logic cmd_legal(
    input cmd_t c
  );
    return c <= CMD_OP_LAST;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: DEPTH entries (power of two), show-ahead read.
// Ports: clk, reset, wr_data/wr_en, rd_en/rd_data, full, empty.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  // A write while full is dropped even if a read frees a slot.
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/lcd_cmd_seq.sv
// LCD command sequencer: queues host commands, issues them to an
// LCD controller with busy/done handshake, flags illegal codes.
// Ports: host_cmd/host_valid/host_ready (push side),
//   busy/done (controller status), cmd/cmd_valid (issue),
//   frame_done, err (sticky), issued_cnt (wrapping count).
import lcd_cmd_seq_pkg::*;

module lcd_cmd_seq #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] host_cmd,
  input  logic       host_valid,
  output logic       host_ready,
  input  logic       busy,
  input  logic       done,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic       frame_done,
  output logic       err,
  output logic [7:0] issued_cnt
);

  state_t     state_q;
  state_t     state_d;
  cmd_t       head;
  cmd_t       cmd_d;
  logic       cmd_valid_d;
  logic       frame_done_d;
  logic       err_d;
  logic [7:0] cnt_d;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;

  assign host_ready = !fifo_full;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_data (host_cmd),
    .wr_en   (host_valid),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd;
    cmd_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    err_d        = err;
    cnt_d        = issued_cnt;
    pop          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && !busy) begin
          pop = 1'b1;
          if (cmd_legal(head)) begin
            cmd_d       = head;
            cmd_valid_d = 1'b1;
            cnt_d       = issued_cnt + 8'd1;
            state_d     = WAIT_BUSY;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_BUSY: begin
        // Only a write waits for the frame to complete.
        if (busy) begin
          state_d = (cmd == CMD_WRITE) ? WAIT_DONE : IDLE;
        end
      end
      WAIT_DONE: begin
        if (done) begin
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cmd        <= CMD_WRITE;
      cmd_valid  <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      issued_cnt <= '0;
    end else begin
      state_q    <= state_d;
      cmd        <= cmd_d;
      cmd_valid  <= cmd_valid_d;
      frame_done <= frame_done_d;
      err        <= err_d;
      issued_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Bench for lcd_cmd_seq: scoreboard of legal pushed commands
// checked against each cmd_valid issue, plus directed checks.
import lcd_cmd_seq_pkg::*;

module tb_lcd_cmd_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] host_cmd;
  logic       host_valid;
  logic       host_ready;
  logic       busy;
  logic       done;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic       frame_done;
  logic       err;
  logic [7:0] issued_cnt;

  logic       auto_busy;
  logic       busy_auto;
  logic       busy_force;

  assign busy = auto_busy ? busy_auto : busy_force;

  lcd_cmd_seq #(
    .DEPTH (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .host_cmd   (host_cmd),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .busy       (busy),
    .done       (done),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .frame_done (frame_done),
    .err        (err),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] sb[$];
  logic [7:0] exp_cnt;
  logic       prev_valid;
  int         n_issued;
  int         n_acc;
  int         base_i;
  int         base_a;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; check any issue against the scoreboard and run
  // the controller model (busy follows cmd_valid by one cycle).
  task automatic step();
    logic [3:0] e;
    @(posedge clk);
    #1;
    if (cmd_valid === 1'b1) begin
      chk("no_back_to_back", 32'(prev_valid), 32'd0);
      if (sb.size() == 0) begin
        chk("issue_expected", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        exp_cnt = exp_cnt + 8'd1;
        n_issued++;
        chk("cmd", 32'(cmd), 32'(e));
        chk("issued_cnt", 32'(issued_cnt), 32'(exp_cnt));
      end
    end
    prev_valid = cmd_valid;
    if (auto_busy) busy_auto = cmd_valid;
  endtask

  task automatic push(input logic [3:0] c);
    host_cmd   = c;
    host_valid = 1'b1;
    if (host_ready === 1'b1) begin
      n_acc++;
      if (c <= 4'd11) sb.push_back(c);
    end
    step();
    host_valid = 1'b0;
  endtask

  task automatic drain(input int max);
    int k = 0;
    while (sb.size() != 0 && k < max) begin
      step();
      k++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    host_cmd   = 4'd0;
    host_valid = 1'b0;
    done       = 1'b0;
    auto_busy  = 1'b0;
    busy_auto  = 1'b0;
    busy_force = 1'b0;
    exp_cnt    = 8'd0;
    prev_valid = 1'b0;
    n_issued   = 0;
    n_acc      = 0;
    step();
    step();
    reset = 1'b0;

    chk("rst_host_ready", 32'(host_ready), 32'd1);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_issued_cnt", 32'(issued_cnt), 32'd0);

    // Basic ordered issue ending on a write.
    auto_busy = 1'b1;
    push(4'd1);
    push(4'd4);
    push(4'd7);
    push(4'd0);
    drain(40);
    step();
    chk("cnt_after_4", 32'(issued_cnt), 32'd4);
    chk("state_wait_done", 32'(dut.state_q), 32'(WAIT_DONE));
    repeat (3) step();
    chk("frame_done_idle", 32'(frame_done), 32'd0);

    done = 1'b1;
    step();
    done = 1'b0;
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    chk("state_idle", 32'(dut.state_q), 32'(IDLE));
    step();
    chk("frame_done_once", 32'(frame_done), 32'd0);

    // Fill while the controller is busy.
    auto_busy  = 1'b0;
    busy_force = 1'b1;
    base_a     = n_acc;
    base_i     = n_issued;
    for (int i = 0; i < 9; i++) push(4'(1 + (i % 11)));
    chk("fill_accepted", 32'(n_acc - base_a), 32'd8);
    chk("full_not_ready", 32'(host_ready), 32'd0);
    chk("no_issue_busy", 32'(n_issued - base_i), 32'd0);
    busy_force = 1'b0;
    busy_auto  = 1'b0;
    auto_busy  = 1'b1;
    drain(60);
    repeat (4) step();
    chk("issued_8", 32'(n_issued - base_i), 32'd8);
    chk("ready_again", 32'(host_ready), 32'd1);

    // Illegal code dropped, next legal one issued.
    base_i = n_issued;
    chk("err_before", 32'(err), 32'd0);
    push(4'd13);
    push(4'd5);
    drain(20);
    repeat (3) step();
    chk("err_set", 32'(err), 32'd1);
    chk("one_issued", 32'(n_issued - base_i), 32'd1);
    chk("cnt_plus_1", 32'(issued_cnt), 32'(exp_cnt));

    // Reset while waiting for busy with entries queued.
    auto_busy  = 1'b0;
    busy_auto  = 1'b0;
    busy_force = 1'b0;
    push(4'd2);
    push(4'd3);
    push(4'd4);
    push(4'd5);
    chk("state_wait_busy", 32'(dut.state_q), 32'(WAIT_BUSY));
    chk("queued_3", 32'(sb.size()), 32'd3);
    reset = 1'b1;
    sb.delete();
    exp_cnt = 8'd0;
    step();
    reset = 1'b0;
    chk("rr_cmd", 32'(cmd), 32'd0);
    chk("rr_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rr_err", 32'(err), 32'd0);
    chk("rr_frame_done", 32'(frame_done), 32'd0);
    chk("rr_issued_cnt", 32'(issued_cnt), 32'd0);
    chk("rr_host_ready", 32'(host_ready), 32'd1);
    chk("rr_fifo_empty", 32'(dut.fifo_empty), 32'd1);
    base_i = n_issued;
    repeat (6) step();
    chk("rr_no_issue", 32'(n_issued - base_i), 32'd0);

    // Counter wrap after 256 issues.
    auto_busy = 1'b1;
    base_a    = n_acc;
    base_i    = n_issued;
    for (int k = 0; k < 3000 && (n_acc - base_a) < 256; k++) begin
      push(4'(1 + (k % 11)));
    end
    drain(100);
    step();
    chk("wrap_issued", 32'(n_issued - base_i), 32'd256);
    chk("wrap_cnt", 32'(issued_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
